alu_result_tx: RTL
==================

# alu_result_tx

Result serializer sitting directly downstream of the command FSM / ALU. It merges two sources toward the UART transmitter: a wide ALU result word, and a byte stream passed through for the ECHO opcode. The ALU result is latched in one cycle and shifted out least-significant byte first, one byte per accepted transfer. ECHO bytes are passed straight through while no result is pending.

## Interface
- `WIDTH_BYTES`, default 8: result word width in bytes; legal range 1..8.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `result_i`  in  8*WIDTH_BYTES  ALU result word.
- `len_i`  in  4  number of bytes of `result_i` to transmit. 0 or any value > `WIDTH_BYTES` means `WIDTH_BYTES`.
- `result_valid_i`  in  1  result word and length valid.
- `result_ready_o`  out  1  serializer can latch a result.
- `echo_data_i`  in  8  ECHO byte from the FSM.
- `echo_valid_i`  in  1  ECHO byte valid.
- `echo_ready_o`  out  1  ECHO byte accepted this cycle.
- `data_o`  out  8  byte to the UART transmitter.
- `valid_o`  out  1  `data_o` valid.
- `ready_i`  in  1  UART transmitter accepts a byte.
- `busy_o`  out  1  high while a result is being serialized.

## Operation
- States: IDLE, SEND.
- A transfer on any interface occurs on a cycle where valid and ready are both high.

IDLE
- `result_ready_o` = 1.
- `busy_o` = 0.
- ECHO passthrough, all combinational:
  - `data_o` = `echo_data_i`.
  - `valid_o` = `echo_valid_i & ~result_valid_i`.
  - `echo_ready_o` = `ready_i & ~result_valid_i`.
- On a result transfer:
  - `shift_q` <= `result_i`.
  - `remain_q` <= effective length.
  - Go to SEND.
- Simultaneous result and ECHO valid: the result wins. The ECHO byte is not accepted (`echo_ready_o` = 0) and must be held by the producer.

SEND
- `valid_o` = 1.
- `data_o` = `shift_q[7:0]`.
- `result_ready_o` = 0.
- `echo_ready_o` = 0.
- `busy_o` = 1.
- On `ready_i`:
  - `shift_q` <= `shift_q >> 8`, zero-filled.
  - `remain_q` <= `remain_q - 1`.
  - If `remain_q` == 1, go to IDLE.
- `ready_i` low: `data_o` and `valid_o` hold steady. Valid is never withdrawn once asserted in SEND.

Arithmetic
- `remain_q` is 4 bits wide and is never decremented below 1 while in SEND.
- Bytes beyond the effective length are never emitted.

## Timing
- Reset (rst high at a clock edge):
  - State -> IDLE.
  - `shift_q` = 0, `remain_q` = 0.
  - `busy_o` = 0.
  - While `rst` is high, `result_ready_o`, `echo_ready_o` and `valid_o` are forced to 0.
- Reset mid-SEND: the remaining bytes are discarded. No partial byte is emitted after the reset edge.
- Result latency: result accepted at edge N; first byte has `valid_o` = 1 in cycle N+1.
- Throughput: one byte per cycle while `ready_i` is held high. A length-L result occupies SEND for L cycles.
- Back-to-back results: after the last byte transfer, the block spends at least one cycle in IDLE before the next result is accepted. `result_ready_o` goes high the cycle after the last byte.
- ECHO path: zero-cycle combinational latency, no storage. Any ECHO byte offered during SEND is stalled.
- `data_o` is don't-care when `valid_o` = 0. The bench checks it only on transfers.

## Test plan
- Reset, then idle with no inputs → `valid_o` = 0, `busy_o` = 0, `result_ready_o` = 1 after `rst` falls.
- `WIDTH_BYTES` = 8, `result_i` = 0x0807060504030201, `len_i` = 8, `ready_i` held 1 → bytes 01..08 on 8 consecutive cycles starting at N+1. `busy_o` falls after byte 08; `result_ready_o` high the cycle after.
- `len_i` = 2, `result_i` = 0x...BEEF, `ready_i` toggled 1,0,0,1 → EF transferred, then EF-successor BE held stable through two stall cycles, then transferred; exactly 2 bytes emitted.
- ECHO stream 0x41, 0x42, 0x43 in IDLE with `ready_i` = 1 → same bytes on `data_o`, one per cycle, `echo_ready_o` = 1 each cycle.
- `result_valid_i` and `echo_valid_i` asserted in the same cycle → result latched, `echo_ready_o` = 0 throughout SEND. ECHO byte emitted only after return to IDLE.
- `rst` asserted after 3 of 8 bytes → `valid_o` = 0 from that edge. A new result after reset is serialized from byte 0 with correct values.

Source files
------------

// File: rtl/alu_result_tx.sv
// Serializes a latched ALU result word LSB-first toward the UART transmitter,
// and passes ECHO bytes through combinationally while no result is pending.
module alu_result_tx #(
    parameter int WIDTH_BYTES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*WIDTH_BYTES-1:0] result_i,
    input  logic [3:0]               len_i,
    input  logic                     result_valid_i,
    output logic                     result_ready_o,
    input  logic [7:0]               echo_data_i,
    input  logic                     echo_valid_i,
    output logic                     echo_ready_o,
    output logic [7:0]               data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     busy_o
);
    localparam int         W        = 8 * WIDTH_BYTES;
    localparam logic [3:0] FULL_LEN = 4'(WIDTH_BYTES);

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [3:0]     remain_q, remain_d;
    logic [3:0]     eff_len;

    // Zero or an over-long length request means the whole word.
    assign eff_len = (len_i == 4'd0 || len_i > FULL_LEN) ? FULL_LEN : len_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            remain_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            remain_q <= remain_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        remain_d       = remain_q;
        result_ready_o = 1'b0;
        echo_ready_o   = 1'b0;
        valid_o        = 1'b0;
        data_o         = echo_data_i;
        busy_o         = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A pending result blocks the ECHO path so the result wins ties.
                result_ready_o = ~rst;
                valid_o        = echo_valid_i & ~result_valid_i & ~rst;
                echo_ready_o   = ready_i & ~result_valid_i & ~rst;
                if (result_valid_i) begin
                    shift_d  = result_i;
                    remain_d = eff_len;
                    state_d  = SEND;
                end
            end
            SEND: begin
                valid_o = ~rst;
                data_o  = shift_q[7:0];
                busy_o  = 1'b1;
                if (ready_i) begin
                    shift_d  = shift_q >> 8;
                    remain_d = remain_q - 4'd1;
                    if (remain_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
